// File: rtl/sobel_pkg.sv
// Shared constants, window type and kernel helper for the Sobel edge pipeline.
// Latency: not applicable (definitions only).
// Backpressure: none; the video path free-runs at the pixel clock.
package sobel_pkg;

  localparam int GRAD_W       = 11;    // signed gradient / unsigned magnitude width
  localparam int CNT_W        = 11;    // h_cnt / v_cnt width
  localparam int PIPE_LAT     = 4;     // input-to-output latency in clocks
  localparam int H_ACTIVE_DEF = 1920;
  localparam int V_ACTIVE_DEF = 1080;

  // Sobel kernel weights: outer taps weigh 1, the centre tap weighs 2.
  localparam logic [GRAD_W-1:0] KW_SIDE = 11'd1;
  localparam logic [GRAD_W-1:0] KW_MID  = 11'd2;

  typedef logic [7:0] pix_t;

  // 3x3 window indexed [row][col]; row 0 = oldest line (y-2), col 2 = newest column.
  typedef logic [2:0][2:0][7:0] win_t;

  // Weighted sum of one kernel column or row: a*1 + b*2 + c*1 (max 1020).
  function automatic logic [GRAD_W-1:0] kern_sum(input pix_t a, input pix_t b, input pix_t c);
    return GRAD_W'(a) * KW_SIDE + GRAD_W'(b) * KW_MID + GRAD_W'(c) * KW_SIDE;
  endfunction

endpackage

// File: rtl/sobel_window_3x3.sv
// 3x3 luma window shift registers plus pixel/line counters and the border flag.
// Latency: 1 clock from tap input to window/border output.
// Backpressure: none; the window shifts only on in_de=1 and holds otherwise.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_de,
  input  logic       in_vs,
  input  logic [7:0] in_pix,
  input  logic [7:0] line1_pix,
  input  logic [7:0] line2_pix,
  output win_t       win,
  output logic       border
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             de_d;
  logic             vs_d;
  logic             de_fall;
  logic             vs_rise;

  assign de_fall = de_d & ~in_de;
  assign vs_rise = in_vs & ~vs_d;

  // Remember previous DE/VS so line ends and frame starts can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_d <= in_de;
      vs_d <= in_vs;
    end
  end

  // Column counter: counts active pixels, wraps at the line width, and is
  // cleared at the end of a short line so the next line starts at column 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
    end else if (in_de) begin
      h_cnt <= (h_cnt == CNT_W'(H_ACTIVE - 1)) ? '0 : h_cnt + 1'b1;
    end else if (de_fall) begin
      h_cnt <= '0;
    end
  end

  // Line counter: advances at each line end; a frame start overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_cnt <= '0;
    end else if (vs_rise) begin
      v_cnt <= '0;
    end else if (de_fall) begin
      v_cnt <= (v_cnt == CNT_W'(V_ACTIVE - 1)) ? '0 : v_cnt + 1'b1;
    end
  end

  // Shift a new column of taps into the window and tag it as border or interior.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win    <= '0;
      border <= 1'b0;
    end else if (in_de) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= line2_pix;
      win[1][2] <= line1_pix;
      win[2][2] <= in_pix;
      border    <= (h_cnt < CNT_W'(2)) || (v_cnt < CNT_W'(2));
    end
  end

endmodule

// File: rtl/sobel_edge_3x3.sv
// Sobel |Gx|+|Gy| gradient with threshold, plus matching DE/HS/VS delay line.
// Latency: 4 clocks from taps/syncs in to out_* for every signal.
// Backpressure: none; free-running pipeline, consumers qualify data with out_de.
module sobel_edge_3x3
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_de,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic [7:0] in_pix,
  input  logic [7:0] line1_pix,
  input  logic [7:0] line2_pix,
  input  logic [7:0] threshold,
  output logic       out_de,
  output logic       out_hs,
  output logic       out_vs,
  output logic [7:0] out_mag,
  output logic [7:0] out_edge
);

  win_t                     win;
  logic                     border1;
  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic                     border2;
  logic        [GRAD_W-1:0] gx_abs;
  logic        [GRAD_W-1:0] gy_abs;
  logic        [GRAD_W-1:0] mag;
  logic      [PIPE_LAT-1:0] de_sr;
  logic      [PIPE_LAT-1:0] hs_sr;
  logic      [PIPE_LAT-1:0] vs_sr;

  // Stage 1: window and border flag.
  sobel_window_3x3 #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .in_de     (in_de),
    .in_vs     (in_vs),
    .in_pix    (in_pix),
    .line1_pix (line1_pix),
    .line2_pix (line2_pix),
    .win       (win),
    .border    (border1)
  );

  // Stage 2: directional gradients; +/-1020 fits 11-bit signed without overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx      <= '0;
      gy      <= '0;
      border2 <= 1'b0;
    end else begin
      gx      <= $signed(kern_sum(win[0][2], win[1][2], win[2][2])
                       - kern_sum(win[0][0], win[1][0], win[2][0]));
      gy      <= $signed(kern_sum(win[2][0], win[2][1], win[2][2])
                       - kern_sum(win[0][0], win[0][1], win[0][2]));
      border2 <= border1;
    end
  end

  assign gx_abs = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
  assign gy_abs = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);

  // Stage 3: L1 magnitude (max 2040), suppressed where the window is incomplete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
    end else begin
      mag <= border2 ? '0 : gx_abs + gy_abs;
    end
  end

  // Stage 4: saturate magnitude to 8 bits and apply the strict threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mag  <= 8'h00;
      out_edge <= 8'h00;
    end else begin
      out_mag  <= (mag > GRAD_W'(255)) ? 8'hFF : mag[7:0];
      out_edge <= (mag > {3'b000, threshold}) ? 8'hFF : 8'h00;
    end
  end

  // Sync delay line: unqualified, same depth as the data pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[PIPE_LAT-2:0], in_de};
      hs_sr <= {hs_sr[PIPE_LAT-2:0], in_hs};
      vs_sr <= {vs_sr[PIPE_LAT-2:0], in_vs};
    end
  end

  assign out_de = de_sr[PIPE_LAT-1];
  assign out_hs = hs_sr[PIPE_LAT-1];
  assign out_vs = vs_sr[PIPE_LAT-1];

endmodule
